// File: rtl/tl_host_bram.sv
// tl_host_bram: single-port memory-style requester -> TileLink-UL host port.
// Up to NumOutstanding beats may be in flight. Each beat uses the slot index
// as its source ID. Channel D may answer out of order, and the slot array
// acts as a reorder buffer so responses retire in issue order.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*               request handshake (we / word addr / byte mask / data)
//   rsp_*               in-order response handshake (we echo / rdata / error)
//   device_a_*          TL-UL channel A (host -> device)
//   device_d_*          TL-UL channel D (device -> host)
module tl_host_bram #(
  parameter int DataWidth      = 64,
  parameter int AddrWidth      = 56,
  parameter int SourceWidth    = 2,
  parameter int SinkWidth      = 1,
  parameter int BramAddrWidth  = 53,
  parameter int NumOutstanding = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [BramAddrWidth-1:0] req_addr_i,
  input  logic [DataWidth/8-1:0]   req_wmask_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     rsp_we_o,
  output logic [DataWidth-1:0]     rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic                     device_a_valid_o,
  input  logic                     device_a_ready_i,
  output logic [2:0]               device_a_opcode_o,
  output logic [2:0]               device_a_param_o,
  output logic [2:0]               device_a_size_o,
  output logic [SourceWidth-1:0]   device_a_source_o,
  output logic [AddrWidth-1:0]     device_a_address_o,
  output logic [DataWidth/8-1:0]   device_a_mask_o,
  output logic                     device_a_corrupt_o,
  output logic [DataWidth-1:0]     device_a_data_o,
  input  logic                     device_d_valid_i,
  output logic                     device_d_ready_o,
  input  logic [2:0]               device_d_opcode_i,
  input  logic [1:0]               device_d_param_i,
  input  logic [2:0]               device_d_size_i,
  input  logic [SourceWidth-1:0]   device_d_source_i,
  input  logic [SinkWidth-1:0]     device_d_sink_i,
  input  logic                     device_d_denied_i,
  input  logic                     device_d_corrupt_i,
  input  logic [DataWidth-1:0]     device_d_data_i
);
  localparam int MaskW = DataWidth / 8;
  localparam int OffW  = $clog2(MaskW);
  localparam int PtrW  = $clog2(NumOutstanding);
  localparam int CntW  = PtrW + 1;

  localparam logic [2:0] OpPutFull  = 3'd0;
  localparam logic [2:0] OpPutPart  = 3'd1;
  localparam logic [2:0] OpGet      = 3'd4;
  localparam logic [2:0] OpAck      = 3'd0;
  localparam logic [2:0] OpAckData  = 3'd1;

  logic [PtrW-1:0]                          issue_ptr_q, issue_ptr_d;
  logic [PtrW-1:0]                          retire_ptr_q, retire_ptr_d;
  logic [CntW-1:0]                          count_q, count_d;
  logic [NumOutstanding-1:0]                we_q, we_d;
  logic [NumOutstanding-1:0]                done_q, done_d;
  logic [NumOutstanding-1:0]                err_q, err_d;
  logic [NumOutstanding-1:0][DataWidth-1:0] data_q, data_d;
  logic                                     protocol_err_q, protocol_err_d;
  logic                                     d_ready_q, d_ready_d;

  logic            full, a_fire, d_fire, d_hit, src_ok, rsp_fire;
  logic [PtrW-1:0] d_idx, d_ofs;
  logic [2:0]      d_exp_op;

  // d_param, d_size and d_sink carry nothing this host needs.
  logic unused_d;
  assign unused_d = ^{device_d_param_i, device_d_size_i, device_d_sink_i};

  // Full looks only at the registered count, so a retire in this cycle
  // cannot open the A channel combinationally.
  assign full   = (count_q == CntW'(NumOutstanding));
  assign a_fire = req_valid_i && !full && device_a_ready_i;
  assign d_fire = device_d_valid_i && d_ready_q;

  // A D beat is accepted only if its source names a slot that lies inside
  // the in-flight window [retire_ptr, retire_ptr + count) and is still open.
  assign src_ok   = ({1'b0, device_d_source_i} < (SourceWidth+1)'(NumOutstanding));
  assign d_idx    = device_d_source_i[PtrW-1:0];
  assign d_ofs    = d_idx - retire_ptr_q;
  assign d_hit    = d_fire && src_ok && ({1'b0, d_ofs} < count_q) && !done_q[d_idx];
  assign d_exp_op = we_q[d_idx] ? OpAck : OpAckData;

  assign rsp_valid_o = done_q[retire_ptr_q] && (count_q != '0);
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;
  assign rsp_we_o    = we_q[retire_ptr_q];
  assign rsp_rdata_o = we_q[retire_ptr_q] ? '0 : data_q[retire_ptr_q];
  assign rsp_error_o = err_q[retire_ptr_q];

  assign req_ready_o        = device_a_ready_i && !full;
  assign device_a_valid_o   = req_valid_i && !full;
  assign device_a_opcode_o  = !req_we_i ? OpGet : (&req_wmask_i ? OpPutFull : OpPutPart);
  assign device_a_param_o   = 3'd0;
  assign device_a_size_o    = 3'(OffW);
  assign device_a_source_o  = SourceWidth'(issue_ptr_q);
  assign device_a_address_o = AddrWidth'({req_addr_i, {OffW{1'b0}}});
  assign device_a_mask_o    = req_we_i ? req_wmask_i : {MaskW{1'b1}};
  assign device_a_corrupt_o = 1'b0;
  assign device_a_data_o    = req_we_i ? req_wdata_i : '0;
  assign device_d_ready_o   = d_ready_q;

  always_comb begin
    issue_ptr_d    = issue_ptr_q;
    retire_ptr_d   = retire_ptr_q;
    we_d           = we_q;
    done_d         = done_q;
    err_d          = err_q;
    data_d         = data_q;
    d_ready_d      = 1'b1;
    protocol_err_d = protocol_err_q | (d_fire & ~d_hit);
    count_d        = count_q + CntW'(a_fire) - CntW'(rsp_fire);

    if (a_fire) begin
      we_d[issue_ptr_q]   = req_we_i;
      done_d[issue_ptr_q] = 1'b0;
      issue_ptr_d         = issue_ptr_q + PtrW'(1);
    end
    // The slot just issued is never in flight yet, and the retiring slot is
    // already done, so none of these three updates touch the same slot.
    if (d_hit) begin
      done_d[d_idx] = 1'b1;
      data_d[d_idx] = device_d_data_i;
      err_d[d_idx]  = device_d_denied_i | device_d_corrupt_i |
                      (device_d_opcode_i != d_exp_op);
    end
    if (rsp_fire) begin
      done_d[retire_ptr_q] = 1'b0;
      retire_ptr_d         = retire_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_ptr_q    <= '0;
      retire_ptr_q   <= '0;
      count_q        <= '0;
      we_q           <= '0;
      done_q         <= '0;
      err_q          <= '0;
      data_q         <= '0;
      protocol_err_q <= 1'b0;
      d_ready_q      <= 1'b0;
    end else begin
      issue_ptr_q    <= issue_ptr_d;
      retire_ptr_q   <= retire_ptr_d;
      count_q        <= count_d;
      we_q           <= we_d;
      done_q         <= done_d;
      err_q          <= err_d;
      data_q         <= data_d;
      protocol_err_q <= protocol_err_d;
      d_ready_q      <= d_ready_d;
    end
  end
endmodule

// File: tb/tb_tl_host_bram.sv
module tb_tl_host_bram;
  localparam int DW = 64;
  localparam int AW = 56;
  localparam int SW = 2;
  localparam int KW = 1;
  localparam int BW = 53;
  localparam int NO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [BW-1:0] req_addr;
  logic [7:0]    req_wmask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_we, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          a_valid, a_ready, a_corrupt;
  logic [2:0]    a_opcode, a_param, a_size;
  logic [SW-1:0] a_source;
  logic [AW-1:0] a_address;
  logic [7:0]    a_mask;
  logic [DW-1:0] a_data;
  logic          d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]    d_opcode, d_size;
  logic [1:0]    d_param;
  logic [SW-1:0] d_source;
  logic [KW-1:0] d_sink;
  logic [DW-1:0] d_data;

  tl_host_bram #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .SinkWidth(KW),
                 .BramAddrWidth(BW), .NumOutstanding(NO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_we_o(rsp_we),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .device_a_valid_o(a_valid), .device_a_ready_i(a_ready), .device_a_opcode_o(a_opcode),
    .device_a_param_o(a_param), .device_a_size_o(a_size), .device_a_source_o(a_source),
    .device_a_address_o(a_address), .device_a_mask_o(a_mask), .device_a_corrupt_o(a_corrupt),
    .device_a_data_o(a_data),
    .device_d_valid_i(d_valid), .device_d_ready_o(d_ready), .device_d_opcode_i(d_opcode),
    .device_d_param_i(d_param), .device_d_size_i(d_size), .device_d_source_i(d_source),
    .device_d_sink_i(d_sink), .device_d_denied_i(d_denied), .device_d_corrupt_i(d_corrupt),
    .device_d_data_i(d_data)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: an issue-ordered list of outstanding requests.
  typedef struct { logic we; int src; logic done; logic [63:0] data; logic err; } ent_t;
  typedef struct { logic we; logic [63:0] data; logic err; } rsp_t;
  ent_t q[$];
  rsp_t rlog[$];
  int   icnt = 0;
  logic dr_exp = 1'b0;

  always @(negedge clk) begin : cmp
    bit full, av, ev, drn;
    int hit;
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_d_ready", d_ready, 0);
      q.delete();
      icnt = 0;
      dr_exp = 1'b0;
    end else begin
      full = (q.size() >= NO);
      av   = req_valid && !full;
      drn  = dr_exp;
      chk("d_ready", d_ready, drn);
      dr_exp = 1'b1;
      chk("req_ready", req_ready, a_ready && !full);
      chk("a_valid", a_valid, av);
      if (av) begin
        chk("a_opcode", a_opcode, !req_we ? 4 : (req_wmask == 8'hFF ? 0 : 1));
        chk("a_address", a_address, {req_addr, 3'b000});
        chk("a_size", a_size, 3);
        chk("a_param", a_param, 0);
        chk("a_corrupt", a_corrupt, 0);
        chk("a_source", a_source, icnt);
        chk("a_mask", a_mask, req_we ? req_wmask : 8'hFF);
        chk("a_data", a_data, req_we ? req_wdata : 64'h0);
      end
      ev = (q.size() > 0) && q[0].done;
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_we", rsp_we, q[0].we);
        chk("rsp_rdata", rsp_rdata, q[0].we ? 64'h0 : q[0].data);
        chk("rsp_error", rsp_error, q[0].err);
      end
      if (d_valid && drn) begin
        hit = -1;
        foreach (q[i]) if (hit < 0 && q[i].src == int'(d_source) && !q[i].done) hit = i;
        if (hit >= 0) begin
          q[hit].done = 1'b1;
          q[hit].data = d_data;
          q[hit].err  = d_denied | d_corrupt | (d_opcode != (q[hit].we ? 3'd0 : 3'd1));
        end
      end
      if (ev && rsp_ready) begin
        rlog.push_back('{rsp_we, rsp_rdata, rsp_error});
        void'(q.pop_front());
      end
      if (av && a_ready) begin
        q.push_back('{req_we, icnt, 1'b0, 64'h0, 1'b0});
        icnt = (icnt + 1) % NO;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; d_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rlog.delete();
  endtask

  task automatic issue(input logic we, input logic [BW-1:0] ad, input logic [7:0] m,
                       input logic [63:0] wd, output int src, output int stall,
                       output logic [2:0] op, output logic [AW-1:0] addr);
    req_valid = 1'b1; req_we = we; req_addr = ad; req_wmask = m; req_wdata = wd;
    src = -1; stall = 0; op = 3'd7; addr = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        src = int'(a_source); op = a_opcode; addr = a_address;
        break;
      end
      stall++;
    end
    if (src < 0) chk("issue_timeout", 0, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic d_send(input int src, input logic [2:0] op, input logic [63:0] dd,
                        input logic den, input logic cor);
    d_valid = 1'b1; d_source = SW'(src); d_opcode = op; d_data = dd;
    d_denied = den; d_corrupt = cor;
    tick();
    d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
  endtask

  task automatic wait_rsp(output rsp_t r, output int lat);
    lat = -1;
    r = '{1'bx, 64'hx, 1'bx};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        r = '{rsp_we, rsp_rdata, rsp_error};
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int src, st, lat;
    logic [2:0] op;
    logic [AW-1:0] ad;
    rsp_t r;
    logic [63:0] dv [5];
    dv = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC,
           64'hDDDD_EEEE_FFFF_0000, 64'h0123_4567_89AB_CDEF};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0;
    req_wdata = '0; rsp_ready = 1'b1; a_ready = 1'b1; d_valid = 1'b0; d_opcode = '0;
    d_param = '0; d_size = 3'd3; d_source = '0; d_sink = '0; d_denied = 1'b0;
    d_corrupt = 1'b0; d_data = '0;

    // Reset state
    @(posedge clk); @(negedge clk);
    chk("reset_rsp_we", rsp_we, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_error", rsp_error, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_a_valid", a_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Device back-pressure on A
    a_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 53'h10;
    @(negedge clk);
    chk("a_stall_req_ready", req_ready, 0);
    chk("a_stall_a_valid", a_valid, 1);
    tick();
    a_ready = 1'b1;

    // Single read to word 0x10
    issue(1'b0, 53'h10, 8'h00, 64'h0, src, st, op, ad);
    chk("rd_src", src, 0);
    chk("rd_opcode", op, 4);
    chk("rd_addr", ad, 56'h80);
    d_send(0, 3'd1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
    wait_rsp(r, lat);
    chk("rd_latency", lat, 0);
    chk("rd_data", r.data, 64'hDEAD_BEEF_CAFE_F00D);
    chk("rd_we", r.we, 0);

    // Full write then partial write
    do_reset();
    issue(1'b1, 53'h20, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, src, st, op, ad);
    chk("wr0_op", op, 0);
    chk("wr0_src", src, 0);
    issue(1'b1, 53'h21, 8'h0F, 64'h1234_5678_9ABC_DEF0, src, st, op, ad);
    chk("wr1_op", op, 1);
    chk("wr1_src", src, 1);
    d_send(0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    wait_rsp(r, lat);
    chk("wr0_rsp_we", r.we, 1);
    chk("wr0_rsp_rdata", r.data, 0);
    d_send(1, 3'd0, 64'h0, 1'b0, 1'b0);
    wait_rsp(r, lat);
    chk("wr1_rsp_we", r.we, 1);
    chk("wr1_rsp_err", r.err, 0);

    // Out-of-order completion, fifth request stalls until first retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 53'(i + 64), 8'h00, 64'h0, src, st, op, ad);
      chk("ooo_issue_src", src, i);
      chk("ooo_issue_stall", st, 0);
    end
    fork
      begin
        issue(1'b0, 53'h99, 8'h00, 64'h0, src, st, op, ad);
      end
      begin
        d_send(3, 3'd1, dv[3], 1'b0, 1'b0);
        d_send(1, 3'd1, dv[1], 1'b0, 1'b0);
        d_send(0, 3'd1, dv[0], 1'b0, 1'b0);
        d_send(2, 3'd1, dv[2], 1'b0, 1'b0);
      end
    join
    chk("fifth_stalled", st > 0, 1);
    chk("fifth_src", src, 0);
    repeat (4) tick();
    chk("ooo_rsp_count", rlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rlog.size()) chk("ooo_rsp_data", rlog[i].data, dv[i]);

    // Full buffer with the requester back-pressuring responses
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, 53'(i), 8'h00, 64'h0, src, st, op, ad);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 53'h77;
    @(negedge clk);
    chk("full_req_ready", req_ready, 0);
    chk("full_a_valid", a_valid, 0);
    tick();
    req_valid = 1'b0;
    d_send(2, 3'd1, dv[2], 1'b0, 1'b0);
    d_send(0, 3'd1, dv[0], 1'b0, 1'b0);
    d_send(3, 3'd1, dv[3], 1'b0, 1'b0);
    d_send(1, 3'd1, dv[1], 1'b0, 1'b0);
    @(negedge clk);
    chk("full_rsp_held", rsp_valid, 1);
    chk("full_still_full", req_ready, 0);
    tick();
    rsp_ready = 1'b1;
    issue(1'b0, 53'h77, 8'h00, 64'h0, src, st, op, ad);
    chk("full_next_src", src, 0);
    d_send(0, 3'd1, dv[4], 1'b0, 1'b0);
    repeat (6) tick();
    chk("full_rsp_count", rlog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rlog.size()) chk("full_rsp_data", rlog[i].data, dv[i]);

    // Error reporting: denied, wrong opcode, then clean
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 53'(i), 8'h00, 64'h0, src, st, op, ad);
    d_send(0, 3'd1, dv[0], 1'b1, 1'b0);
    d_send(1, 3'd0, dv[1], 1'b0, 1'b0);
    d_send(2, 3'd1, dv[2], 1'b0, 1'b0);
    repeat (4) tick();
    chk("err_count", rlog.size(), 3);
    if (rlog.size() == 3) begin
      chk("err_denied", rlog[0].err, 1);
      chk("err_opcode", rlog[1].err, 1);
      chk("err_clean", rlog[2].err, 0);
      chk("err_clean_data", rlog[2].data, dv[2]);
    end

    // Reset with requests in flight; stale D beat is dropped
    do_reset();
    for (int i = 0; i < 3; i++) issue(1'b0, 53'(i), 8'h00, 64'h0, src, st, op, ad);
    do_reset();
    d_send(1, 3'd1, dv[1], 1'b0, 1'b0);
    repeat (3) tick();
    chk("stale_no_rsp", rlog.size(), 0);
    chk("stale_protocol_err", dut.protocol_err_q, 1);
    issue(1'b0, 53'h5, 8'h00, 64'h0, src, st, op, ad);
    chk("post_reset_src", src, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
